regression_ctrl: RTL and testbench
==================================

# regression_ctrl

Top-level sequencer for the linear-regression coefficient datapath. On a `start` request it clears the accumulators, streams `n` samples from the sample memory into the sum registers, then drives the shared multi-cycle divider three times (x̄, ȳ, B1) and loads B0. It presents a start/busy/done handshake to the host and owns every load strobe of the coefficient datapath.

## Interface
- `ADDR_W`, 8, sample-memory address width; max sample count 2^ADDR_W − 1
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `n_samples`  in  ADDR_W  sample count, captured on accepted `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on completion
- `err`  out  1  one-cycle pulse, coincident with `done`, when captured count is 0
- `mem_rd`  out  1  sample-memory read enable (data valid next cycle)
- `mem_addr`  out  ADDR_W  sample-memory read address
- `ld0sum`  out  1  clear Σx, Σy, Σxy, Σx², and error accumulators
- `ldsum`  out  1  accumulate current memory data into sums
- `div_start`  out  1  one-cycle divider launch
- `div_sel`  out  2  divider operand select: 0 = x̄, 1 = ȳ, 2 = B1
- `div_done`  in  1  divider result valid (level; sampled each cycle)
- `ldxbar`, `ldybar`, `ldB1`, `ldB0`  out  1 each  result register loads
- `ld_err`  out  1  accumulate residual² (error pass only)

## Operation
- States: IDLE, CLR, ACC, DRAIN, DX, WX, DY, WY, DB, WB, B0, [ECLR, EACC, EDRAIN], DONE.
- IDLE: all outputs 0. `start`=1 → capture `n_samples` into `n_r`, go CLR. `start` ignored in every other state.
- CLR: `ld0sum`=1, address counter ← 0. If `n_r`==0 → DONE with `err` pending; else → ACC.
- ACC: `mem_rd`=1, `mem_addr`=counter, counter increments; after issuing address `n_r`−1 → DRAIN.
- `ldsum` is `mem_rd` delayed one cycle (registered), so it is high in the cycle after each read, including the single DRAIN cycle. DRAIN → DX.
- DX: `div_start`=1, `div_sel`=0 → WX. WX: `div_sel` held at 0; when `div_done`=1, `ldxbar`=1 in that cycle → DY.
- DY/WY: same with `div_sel`=1, `ldybar` → DB. DB/WB: same with `div_sel`=2, `ldB1` → B0.
- B0: `ldB0`=1 for one cycle (datapath forms ȳ − B1·x̄ combinationally) → ECLR if error pass compiled in, else DONE.
- DONE: `done`=1 (and `err`=1 if count was 0) for one cycle → IDLE.
- `div_done` outside WX/WY/WB is ignored. `div_done` already high on entry to a wait state is accepted in the first wait cycle.
- Counter is ADDR_W wide; it never wraps because terminal address is `n_r`−1 ≤ 2^ADDR_W − 2.

## Timing
- Reset: state IDLE, counter 0, `n_r` 0, `ldsum` pipeline 0; every output 0 in the cycle after the `rst` edge. `rst` mid-operation aborts to IDLE with no `done`.
- `start` sampled at edge 0 → CLR in cycle 1, ACC in cycles 2..n+1 (addresses 0..n−1), `ldsum` in cycles 3..n+2 (DRAIN = cycle n+2), `div_start` in cycle n+3.
- Each divide adds 1 launch cycle + wait cycles until `div_done`; with a zero-wait divider, total latency from `start` to `done` is n + 10 cycles (n > 0, no error pass).
- n = 0: CLR cycle 1, DONE/`err` cycle 2; no `mem_rd`, `ldsum`, or divider activity.
- All outputs are decoded from registered state (plus `div_done` for the three loads); no output depends combinationally on `start`.

## Configuration
- `REGRESSION_ERR_PASS_EN` defined: after B0, a second pass. ECLR (`ld0sum`=1 for the error accumulator only, counter ← 0), EACC re-reads addresses 0..n−1, `ld_err` is `mem_rd` delayed one cycle, EDRAIN is a one-cycle drain, then DONE. Adds n + 2 cycles.
- Undefined: ECLR/EACC/EDRAIN do not exist, `ld_err` tied 0, B0 → DONE.

## Test plan
- Reset mid-ACC (n=20, `rst` in cycle 8) → IDLE next cycle, all outputs 0, no `done`; new `start` runs cleanly.
- n=4, `div_done` returned 3 cycles after each `div_start` → addresses 0,1,2,3 on cycles 2–5, `ldsum` cycles 3–6, `ldxbar`/`ldybar`/`ldB1` each one cycle, `done` at cycle 20.
- n=0 → `err`=`done`=1 at cycle 2, no `mem_rd`/`div_start`.
- `start` held high throughout and re-pulsed while busy → exactly one run; stray `div_done` during ACC ignored.
- n=255 (max) → last address 254… n capped: use n=254 → counter reaches 253, no wrap; `done` at cycle 264 with zero-wait divider.
- With `REGRESSION_ERR_PASS_EN`, n=3 → second read burst 0,1,2 after `ldB0`, `ld_err` three cycles, `done` 5 cycles later than without.

Source files
------------

// File: rtl/regression_ctrl_if.sv
// regression_ctrl_if: host handshake, sample-memory read port and coefficient-datapath
// strobes of the regression sequencer, bundled into one interface.
//   master : the sequencer (drives busy/done/err, memory reads, all load strobes)
//   slave  : host + datapath side (drives start, n_samples, div_done)
// Parameter ADDR_W: sample-memory address width (max sample count 2^ADDR_W - 1).
interface regression_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  // Host handshake
  logic              start;
  logic [ADDR_W-1:0] n_samples;
  logic              busy;
  logic              done;
  logic              err;
  // Sample memory
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  // Coefficient datapath
  logic              ld0sum;
  logic              ldsum;
  logic              div_start;
  logic [1:0]        div_sel;
  logic              div_done;
  logic              ldxbar;
  logic              ldybar;
  logic              ldB1;
  logic              ldB0;
  logic              ld_err;

  modport master (
    input  start, n_samples, div_done,
    output busy, done, err, mem_rd, mem_addr, ld0sum, ldsum, div_start, div_sel,
           ldxbar, ldybar, ldB1, ldB0, ld_err
  );

  modport slave (
    output start, n_samples, div_done,
    input  busy, done, err, mem_rd, mem_addr, ld0sum, ldsum, div_start, div_sel,
           ldxbar, ldybar, ldB1, ldB0, ld_err
  );
endinterface

// File: rtl/regression_ctrl.sv
// regression_ctrl: top-level sequencer of the linear-regression coefficient datapath.
// On an accepted start it clears the sum accumulators, streams n samples from the sample
// memory into the sums, runs the shared multi-cycle divider for x-bar, y-bar and B1, and
// finally loads B0. With a zero-wait divider a run of n > 0 samples takes n + 10 cycles.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (aborts any run without a done pulse)
//   bus  : regression_ctrl_if.master - start/n_samples/busy/done/err host handshake,
//          mem_rd/mem_addr sample reads, ld0sum/ldsum/div_*/ld* datapath strobes
//
// Build option: define REGRESSION_ERR_PASS_EN to add a second read pass after B0 that
// streams the samples again with ld_err strobes (residual accumulation). Without it the
// pass does not exist and ld_err is tied low.
module regression_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input logic                clk,
  input logic                rst,
  regression_ctrl_if.master  bus
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StClr    = 4'd1;
  localparam logic [3:0] StAcc    = 4'd2;
  localparam logic [3:0] StDrain  = 4'd3;
  localparam logic [3:0] StDx     = 4'd4;
  localparam logic [3:0] StWx     = 4'd5;
  localparam logic [3:0] StDy     = 4'd6;
  localparam logic [3:0] StWy     = 4'd7;
  localparam logic [3:0] StDb     = 4'd8;
  localparam logic [3:0] StWb     = 4'd9;
  localparam logic [3:0] StB0     = 4'd10;
  localparam logic [3:0] StDone   = 4'd11;
`ifdef REGRESSION_ERR_PASS_EN
  localparam logic [3:0] StEclr   = 4'd12;
  localparam logic [3:0] StEacc   = 4'd13;
  localparam logic [3:0] StEdrain = 4'd14;
`endif

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic              ldsum_q, ldsum_d;
  logic [ADDR_W-1:0] last_addr;

  // Only meaningful in the read states, where n_q is known to be non-zero.
  assign last_addr = n_q - ADDR_W'(1);

  // Next-state, counter and sample-count capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          n_d     = bus.n_samples;
          state_d = StClr;
        end
      end
      StClr: begin
        cnt_d   = '0;
        state_d = (n_q == '0) ? StDone : StAcc;
      end
      StAcc: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == last_addr) state_d = StDrain;
      end
      StDrain: state_d = StDx;
      StDx:    state_d = StWx;
      StWx:    if (bus.div_done) state_d = StDy;
      StDy:    state_d = StWy;
      StWy:    if (bus.div_done) state_d = StDb;
      StDb:    state_d = StWb;
      StWb:    if (bus.div_done) state_d = StB0;
`ifdef REGRESSION_ERR_PASS_EN
      StB0:    state_d = StEclr;
      StEclr: begin
        cnt_d   = '0;
        state_d = StEacc;
      end
      StEacc: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == last_addr) state_d = StEdrain;
      end
      StEdrain: state_d = StDone;
`else
      StB0:    state_d = StDone;
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sum strobe trails the main-pass read by one cycle, matching memory read latency.
  assign ldsum_d = (state_q == StAcc);

`ifdef REGRESSION_ERR_PASS_EN
  logic ld_err_q, ld_err_d;
  assign ld_err_d = (state_q == StEacc);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      n_q      <= '0;
      ldsum_q  <= 1'b0;
`ifdef REGRESSION_ERR_PASS_EN
      ld_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      ldsum_q  <= ldsum_d;
`ifdef REGRESSION_ERR_PASS_EN
      ld_err_q <= ld_err_d;
`endif
    end
  end

  // Output decode: registered state only, plus div_done for the three result loads.
  logic              busy, done, err, mem_rd, ld0sum, div_start;
  logic              ldxbar, ldybar, ldB1, ldB0;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        div_sel;

  always_comb begin
    busy      = (state_q != StIdle);
    done      = 1'b0;
    err       = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    ld0sum    = 1'b0;
    div_start = 1'b0;
    div_sel   = 2'd0;
    ldxbar    = 1'b0;
    ldybar    = 1'b0;
    ldB1      = 1'b0;
    ldB0      = 1'b0;
    case (state_q)
      StClr: ld0sum = 1'b1;
      StAcc: begin
        mem_rd   = 1'b1;
        mem_addr = cnt_q;
      end
      StDx: div_start = 1'b1;
      StWx: ldxbar = bus.div_done;
      StDy: begin
        div_start = 1'b1;
        div_sel   = 2'd1;
      end
      StWy: begin
        div_sel = 2'd1;
        ldybar  = bus.div_done;
      end
      StDb: begin
        div_start = 1'b1;
        div_sel   = 2'd2;
      end
      StWb: begin
        div_sel = 2'd2;
        ldB1    = bus.div_done;
      end
      StB0: ldB0 = 1'b1;
`ifdef REGRESSION_ERR_PASS_EN
      // Datapath clears only the error accumulator in this state.
      StEclr: ld0sum = 1'b1;
      StEacc: begin
        mem_rd   = 1'b1;
        mem_addr = cnt_q;
      end
`endif
      StDone: begin
        done = 1'b1;
        err  = (n_q == '0);
      end
      default: ;
    endcase
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_addr  = mem_addr;
  assign bus.ld0sum    = ld0sum;
  assign bus.ldsum     = ldsum_q;
  assign bus.div_start = div_start;
  assign bus.div_sel   = div_sel;
  assign bus.ldxbar    = ldxbar;
  assign bus.ldybar    = ldybar;
  assign bus.ldB1      = ldB1;
  assign bus.ldB0      = ldB0;
`ifdef REGRESSION_ERR_PASS_EN
  assign bus.ld_err    = ld_err_q;
`else
  assign bus.ld_err    = 1'b0;
`endif

endmodule

// File: tb/tb_regression_ctrl.sv
// Directed bench for regression_ctrl. Each run records every output per cycle (cycle 1 is
// the cycle after the edge that samples start) and compares the whole trace against a
// cycle map built from the documented timing, plus a few targeted checks per scenario.
module tb_regression_ctrl;
  localparam int AW   = 8;
  localparam int MAXC = 600;
  localparam int VW   = 14 + AW;
`ifdef REGRESSION_ERR_PASS_EN
  localparam bit ErrPass = 1'b1;
`else
  localparam bit ErrPass = 1'b0;
`endif
  // Trace bit positions
  localparam int BBusy = VW - 1;
  localparam int BDone = VW - 2;
  localparam int BErr  = VW - 3;
  localparam int BRd   = VW - 4;
  localparam int BDs   = 7;
  localparam int BLx   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regression_ctrl_if #(.ADDR_W(AW)) bus ();
  regression_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [VW-1:0] obs   [MAXC+1];
  logic [VW-1:0] exp_v [MAXC+1];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [VW-1:0] sample();
    return {bus.busy, bus.done, bus.err, bus.mem_rd, bus.mem_addr, bus.ld0sum, bus.ldsum,
            bus.div_start, bus.div_sel, bus.ldxbar, bus.ldybar, bus.ldB1, bus.ldB0,
            bus.ld_err};
  endfunction

  // Expected per-cycle outputs for count n and divider result lat cycles after launch.
  // stop_at > 0 models a reset during that cycle: everything afterwards is idle.
  task automatic build_exp(input int n, input int lat, input int stop_at);
    int dx, ldx, dy, ldy, db, ldb1, b0, dn;
    logic rd, ld0, ls, ds, lx, ly, lb1, lb0, le, dne;
    logic [1:0] sel;
    logic [AW-1:0] a;
    for (int c = 0; c <= MAXC; c++) exp_v[c] = '0;
    if (n == 0) begin
      exp_v[1][BBusy] = 1'b1;
      exp_v[1][9]     = 1'b1;
      exp_v[2][BBusy] = 1'b1;
      exp_v[2][BDone] = 1'b1;
      exp_v[2][BErr]  = 1'b1;
    end else begin
      dx = n + 3; ldx = dx + lat; dy = ldx + 1; ldy = dy + lat;
      db = ldy + 1; ldb1 = db + lat; b0 = ldb1 + 1;
      dn = ErrPass ? b0 + n + 3 : b0 + 1;
      for (int c = 1; c <= dn; c++) begin
        ld0 = (c == 1) || (ErrPass && c == b0 + 1);
        rd  = (c >= 2 && c <= n + 1) || (ErrPass && c >= b0 + 2 && c <= b0 + n + 1);
        a   = '0;
        if (c >= 2 && c <= n + 1) a = AW'(c - 2);
        else if (rd) a = AW'(c - (b0 + 2));
        ls  = (c >= 3 && c <= n + 2);
        ds  = (c == dx) || (c == dy) || (c == db);
        sel = (c >= dy && c <= ldy) ? 2'd1 : (c >= db && c <= ldb1) ? 2'd2 : 2'd0;
        lx  = (c == ldx);
        ly  = (c == ldy);
        lb1 = (c == ldb1);
        lb0 = (c == b0);
        le  = ErrPass && c >= b0 + 3 && c <= b0 + n + 2;
        dne = (c == dn);
        exp_v[c] = {1'b1, dne, 1'b0, rd, a, ld0, ls, ds, sel, lx, ly, lb1, lb0, le};
      end
    end
    if (stop_at > 0)
      for (int c = stop_at + 1; c <= MAXC; c++) exp_v[c] = '0;
  endtask

  // Launch one run and record ncyc cycles. The divider model raises div_done lat cycles
  // after each div_start. hold keeps start high until done; stray pulses div_done in
  // cycles 2..4; rst_at asserts reset during that cycle.
  task automatic run(input int n, input int lat, input bit hold, input bit stray,
                     input int rst_at, input int ncyc);
    int done_at;
    bit done_seen;
    done_at   = -1;
    done_seen = 1'b0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.n_samples = AW'(n);
    bus.div_done  = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      bus.start    = hold && !done_seen;
      rst          = (c == rst_at);
      bus.div_done = (c == done_at) || (stray && c >= 2 && c <= 4);
      #1;
      obs[c] = sample();
      if (bus.div_start) done_at = c + lat;
      if (bus.done) begin
        done_seen = 1'b1;
        bus.start = 1'b0;
      end
    end
    bus.start    = 1'b0;
    bus.div_done = 1'b0;
    rst          = 1'b0;
  endtask

  function automatic int count_bit(input int b, input int ncyc);
    int k = 0;
    for (int c = 1; c <= ncyc; c++) if (obs[c][b]) k++;
    return k;
  endfunction

  function automatic int first_bit(input int b, input int ncyc);
    for (int c = 1; c <= ncyc; c++) if (obs[c][b]) return c;
    return -1;
  endfunction

  task automatic test_reset();
    logic [VW-1:0] v;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.n_samples = 8'd5;
    bus.div_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    v = sample();
    n_checks++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", v, {VW{1'b0}});
    end
    bus.start = 1'b0;
    bus.div_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_n4_slow_div();
    int mism = 0, first = -1, d;
    run(4, 3, 1'b0, 1'b0, 0, 40);
    build_exp(4, 3, 0);
    for (int c = 1; c <= 40; c++)
      if (obs[c] !== exp_v[c]) begin mism++; if (first < 0) first = c; end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL n4_trace: %0d bad cycles, first %0d got %h expected %h",
               mism, first, obs[first], exp_v[first]);
    end
    d = first_bit(BDone, 40);
    n_checks++;
    if (d !== (ErrPass ? 26 : 20)) begin
      n_fail++;
      $display("FAIL n4_done_cycle: got %0d expected %0d", d, ErrPass ? 26 : 20);
    end
    d = count_bit(BLx, 40);
    n_checks++;
    if (d !== 1) begin
      n_fail++;
      $display("FAIL n4_ldxbar_count: got %0d expected 1", d);
    end
  endtask

  task automatic test_zero_count();
    int mism = 0, first = -1, d;
    run(0, 1, 1'b0, 1'b0, 0, 12);
    build_exp(0, 1, 0);
    for (int c = 1; c <= 12; c++)
      if (obs[c] !== exp_v[c]) begin mism++; if (first < 0) first = c; end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL zero_trace: %0d bad cycles, first %0d got %h expected %h",
               mism, first, obs[first], exp_v[first]);
    end
    d = first_bit(BErr, 12);
    n_checks++;
    if (d !== 2) begin
      n_fail++;
      $display("FAIL zero_err_cycle: got %0d expected 2", d);
    end
    d = count_bit(BRd, 12) + count_bit(BDs, 12);
    n_checks++;
    if (d !== 0) begin
      n_fail++;
      $display("FAIL zero_no_activity: got %0d read/launch cycles expected 0", d);
    end
  endtask

  task automatic test_back_to_back();
    int mism = 0, first = -1, d;
    run(5, 1, 1'b1, 1'b1, 0, 30);
    build_exp(5, 1, 0);
    for (int c = 1; c <= 30; c++)
      if (obs[c] !== exp_v[c]) begin mism++; if (first < 0) first = c; end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL hold_trace: %0d bad cycles, first %0d got %h expected %h",
               mism, first, obs[first], exp_v[first]);
    end
    d = count_bit(BDone, 30);
    n_checks++;
    if (d !== 1) begin
      n_fail++;
      $display("FAIL hold_done_count: got %0d expected 1", d);
    end
  endtask

  task automatic test_reset_mid();
    int mism = 0, first = -1, d;
    run(20, 1, 1'b0, 1'b0, 8, 50);
    build_exp(20, 1, 8);
    for (int c = 1; c <= 50; c++)
      if (obs[c] !== exp_v[c]) begin mism++; if (first < 0) first = c; end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL rstmid_trace: %0d bad cycles, first %0d got %h expected %h",
               mism, first, obs[first], exp_v[first]);
    end
    d = count_bit(BDone, 50);
    n_checks++;
    if (d !== 0) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got %0d done pulses expected 0", d);
    end
    mism = 0;
    first = -1;
    run(2, 1, 1'b0, 1'b0, 0, 25);
    build_exp(2, 1, 0);
    for (int c = 1; c <= 25; c++)
      if (obs[c] !== exp_v[c]) begin mism++; if (first < 0) first = c; end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL rstmid_rerun_trace: %0d bad cycles, first %0d got %h expected %h",
               mism, first, obs[first], exp_v[first]);
    end
  endtask

  task automatic test_max_count();
    int mism = 0, first = -1, d;
    logic [AW-1:0] a;
    run(254, 1, 1'b0, 1'b0, 0, 530);
    build_exp(254, 1, 0);
    for (int c = 1; c <= 530; c++)
      if (obs[c] !== exp_v[c]) begin mism++; if (first < 0) first = c; end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL max_trace: %0d bad cycles, first %0d got %h expected %h",
               mism, first, obs[first], exp_v[first]);
    end
    d = first_bit(BDone, 530);
    n_checks++;
    if (d !== (ErrPass ? 520 : 264)) begin
      n_fail++;
      $display("FAIL max_done_cycle: got %0d expected %0d", d, ErrPass ? 520 : 264);
    end
    a = obs[255][BRd-1 -: AW];
    n_checks++;
    if (a !== 8'd253 || obs[256][BRd] !== 1'b0) begin
      n_fail++;
      $display("FAIL max_last_addr: got addr %0d rd_after %b expected 253 and 0",
               a, obs[256][BRd]);
    end
  endtask

  task automatic test_err_pass_len();
    int mism = 0, first = -1, d;
    run(3, 1, 1'b0, 1'b0, 0, 30);
    build_exp(3, 1, 0);
    for (int c = 1; c <= 30; c++)
      if (obs[c] !== exp_v[c]) begin mism++; if (first < 0) first = c; end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL n3_trace: %0d bad cycles, first %0d got %h expected %h",
               mism, first, obs[first], exp_v[first]);
    end
    d = first_bit(BDone, 30);
    n_checks++;
    if (d !== (ErrPass ? 18 : 13)) begin
      n_fail++;
      $display("FAIL n3_done_cycle: got %0d expected %0d", d, ErrPass ? 18 : 13);
    end
    d = count_bit(0, 30);
    n_checks++;
    if (d !== (ErrPass ? 3 : 0)) begin
      n_fail++;
      $display("FAIL n3_ld_err_count: got %0d expected %0d", d, ErrPass ? 3 : 0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.n_samples = '0;
    bus.div_done  = 1'b0;
    test_reset();
    test_n4_slow_div();
    test_zero_count();
    test_back_to_back();
    test_reset_mid();
    test_max_count();
    test_err_pass_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
